// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters (ALU, MEM), the arbiter, and the
// register-file write port / issue logic.
//   master : requester / consumer side (drives VALID/ADDR/DATA, sees READY and RF outputs)
//   slave  : arbiter side
interface regfile_wb_arbiter_if;
   logic        ALU_VALID;
   logic [4:0]  ALU_ADDR;
   logic [31:0] ALU_DATA;
   logic        ALU_READY;
   logic        MEM_VALID;
   logic [4:0]  MEM_ADDR;
   logic [31:0] MEM_DATA;
   logic        MEM_READY;
   logic        RF_WE;
   logic [4:0]  RF_A3;
   logic [31:0] RF_WD;
   logic [31:0] BUSY_MASK;
   logic        GRANT_MEM;

   modport master (
      output ALU_VALID, ALU_ADDR, ALU_DATA,
      output MEM_VALID, MEM_ADDR, MEM_DATA,
      input  ALU_READY, MEM_READY,
      input  RF_WE, RF_A3, RF_WD, BUSY_MASK, GRANT_MEM
   );

   modport slave (
      input  ALU_VALID, ALU_ADDR, ALU_DATA,
      input  MEM_VALID, MEM_ADDR, MEM_DATA,
      output ALU_READY, MEM_READY,
      output RF_WE, RF_A3, RF_WD, BUSY_MASK, GRANT_MEM
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Two requesters (ALU results, memory loads) each own a one-entry holding slot
// with a valid/ready handshake. One slot is granted per cycle; the granted entry
// moves into a registered output stage driving RF_WE/RF_A3/RF_WD.
// Ports:
//   CLOCK    : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   wb       : slave side of regfile_wb_arbiter_if
//              ALU_*/MEM_* requests and READY, RF_WE/RF_A3/RF_WD write port,
//              BUSY_MASK pending-write mask, GRANT_MEM source of current write
module regfile_wb_arbiter #(
   parameter int unsigned PRIO_MODE        = 0, // 0 round-robin, 1 MEM over ALU
   parameter int unsigned ALU_FIRST_ON_TIE = 1  // ALU older on simultaneous load
) (
   input logic                 CLOCK,
   input logic                 RESET_N,
   regfile_wb_arbiter_if.slave wb
);

   logic        alu_full_q, alu_full_d;
   logic [4:0]  alu_addr_q;
   logic [31:0] alu_data_q;
   logic        mem_full_q, mem_full_d;
   logic [4:0]  mem_addr_q;
   logic [31:0] mem_data_q;
   logic        mem_older_q, mem_older_d; // 1: MEM slot was loaded before ALU slot
   logic        rr_mem_q, rr_mem_d;       // 1: MEM is next in round-robin
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_a3_q;
   logic [31:0] rf_wd_q;
   logic        grant_mem_q;

   logic        gnt_alu, gnt_mem;
   logic        alu_load, mem_load;
   logic        both_full, same_addr;
   logic [4:0]  gnt_addr;
   logic [31:0] gnt_data;
   logic [31:0] busy_mask;

   assign both_full = alu_full_q & mem_full_q;
   assign same_addr = (alu_addr_q == mem_addr_q);

   // Grant from registered slot state only, so READY never depends on VALID.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      if (both_full) begin
         if (same_addr) begin
            // Same destination: keep program order regardless of mode.
            gnt_mem = mem_older_q;
         end else if (PRIO_MODE != 0) begin
            gnt_mem = 1'b1;
         end else begin
            gnt_mem = rr_mem_q;
         end
         gnt_alu = ~gnt_mem;
      end else begin
         gnt_alu = alu_full_q;
         gnt_mem = mem_full_q;
      end
   end

   // A granted slot drains this edge, so it may refill in the same cycle.
   assign wb.ALU_READY = ~alu_full_q | gnt_alu;
   assign wb.MEM_READY = ~mem_full_q | gnt_mem;
   assign alu_load     = wb.ALU_VALID & wb.ALU_READY;
   assign mem_load     = wb.MEM_VALID & wb.MEM_READY;

   assign gnt_addr = gnt_mem ? mem_addr_q : alu_addr_q;
   assign gnt_data = gnt_mem ? mem_data_q : alu_data_q;

   always_comb begin
      alu_full_d  = alu_load | (alu_full_q & ~gnt_alu);
      mem_full_d  = mem_load | (mem_full_q & ~gnt_mem);
      mem_older_d = mem_older_q;
      if (alu_load && mem_load) begin
         mem_older_d = (ALU_FIRST_ON_TIE == 0);
      end else if (alu_load) begin
         // New ALU entry is younger than any MEM entry that stays.
         mem_older_d = mem_full_q & ~gnt_mem;
      end else if (mem_load) begin
         mem_older_d = ~(alu_full_q & ~gnt_alu);
      end
      // Pointer only moves on contended grants, pointing away from the winner.
      rr_mem_d = both_full ? gnt_alu : rr_mem_q;
      // Writes to r0 are dropped here but still free their slot.
      rf_we_d  = (gnt_alu | gnt_mem) & (gnt_addr != 5'd0);
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         alu_full_q  <= 1'b0;
         alu_addr_q  <= '0;
         alu_data_q  <= '0;
         mem_full_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_older_q <= 1'b0;
         rr_mem_q    <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_a3_q     <= '0;
         rf_wd_q     <= '0;
         grant_mem_q <= 1'b0;
      end else begin
         alu_full_q  <= alu_full_d;
         mem_full_q  <= mem_full_d;
         mem_older_q <= mem_older_d;
         rr_mem_q    <= rr_mem_d;
         rf_we_q     <= rf_we_d;
         if (alu_load) begin
            alu_addr_q <= wb.ALU_ADDR;
            alu_data_q <= wb.ALU_DATA;
         end
         if (mem_load) begin
            mem_addr_q <= wb.MEM_ADDR;
            mem_data_q <= wb.MEM_DATA;
         end
         if (rf_we_d) begin
            rf_a3_q     <= gnt_addr;
            rf_wd_q     <= gnt_data;
            grant_mem_q <= gnt_mem;
         end
      end
   end

   always_comb begin
      busy_mask = '0;
      if (alu_full_q) busy_mask[alu_addr_q] = 1'b1;
      if (mem_full_q) busy_mask[mem_addr_q] = 1'b1;
      if (rf_we_q)    busy_mask[rf_a3_q]    = 1'b1;
      busy_mask[0] = 1'b0;
   end

   assign wb.RF_WE     = rf_we_q;
   assign wb.RF_A3     = rf_a3_q;
   assign wb.RF_WD     = rf_wd_q;
   assign wb.GRANT_MEM = grant_mem_q;
   assign wb.BUSY_MASK = busy_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: dut0 round-robin, dut1 fixed MEM priority.
// Expected writes are queued per DUT as stimulus is issued; a monitor per DUT
// pops and compares whenever RF_WE is high.
module tb_regfile_wb_arbiter;

   logic CLOCK;
   logic RESET_N;

   regfile_wb_arbiter_if bus0 ();
   regfile_wb_arbiter_if bus1 ();

   regfile_wb_arbiter #(.PRIO_MODE(0), .ALU_FIRST_ON_TIE(1)) dut0 (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .wb      (bus0)
   );

   regfile_wb_arbiter #(.PRIO_MODE(1), .ALU_FIRST_ON_TIE(1)) dut1 (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .wb      (bus1)
   );

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic        src;
   } wr_t;

   wr_t q0[$];
   wr_t q1[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   localparam bit A = 1'b0;
   localparam bit M = 1'b1;

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int dut, input logic [4:0] a, input logic [31:0] d,
                           input bit src);
      wr_t e;
      e.a = a;
      e.d = d;
      e.src = src;
      if (dut == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   always @(negedge CLOCK) begin
      wr_t e;
      if (bus0.RF_WE === 1'b1) begin
         n_tests++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL dut0 write: got unexpected a=%0d d=0x%08h mem=%0b, required none",
                     bus0.RF_A3, bus0.RF_WD, bus0.GRANT_MEM);
         end else begin
            e = q0.pop_front();
            if ({bus0.RF_A3, bus0.RF_WD, bus0.GRANT_MEM} !== e) begin
               n_fail++;
               $display("FAIL dut0 write: got a=%0d d=0x%08h mem=%0b, required a=%0d d=0x%08h mem=%0b",
                        bus0.RF_A3, bus0.RF_WD, bus0.GRANT_MEM, e.a, e.d, e.src);
            end
         end
      end
   end

   always @(negedge CLOCK) begin
      wr_t e;
      if (bus1.RF_WE === 1'b1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL dut1 write: got unexpected a=%0d d=0x%08h mem=%0b, required none",
                     bus1.RF_A3, bus1.RF_WD, bus1.GRANT_MEM);
         end else begin
            e = q1.pop_front();
            if ({bus1.RF_A3, bus1.RF_WD, bus1.GRANT_MEM} !== e) begin
               n_fail++;
               $display("FAIL dut1 write: got a=%0d d=0x%08h mem=%0b, required a=%0d d=0x%08h mem=%0b",
                        bus1.RF_A3, bus1.RF_WD, bus1.GRANT_MEM, e.a, e.d, e.src);
            end
         end
      end
   end

   task automatic set_req(input int dut, input bit mem, input logic v, input logic [4:0] a,
                          input logic [31:0] d);
      if (dut == 0) begin
         if (mem) begin bus0.MEM_VALID = v; bus0.MEM_ADDR = a; bus0.MEM_DATA = d; end
         else     begin bus0.ALU_VALID = v; bus0.ALU_ADDR = a; bus0.ALU_DATA = d; end
      end else begin
         if (mem) begin bus1.MEM_VALID = v; bus1.MEM_ADDR = a; bus1.MEM_DATA = d; end
         else     begin bus1.ALU_VALID = v; bus1.ALU_ADDR = a; bus1.ALU_DATA = d; end
      end
   endtask

   function automatic logic get_ready(input int dut, input bit mem);
      if (dut == 0) return mem ? bus0.MEM_READY : bus0.ALU_READY;
      return mem ? bus1.MEM_READY : bus1.ALU_READY;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int dut, input bit mem, input logic [4:0] a, input logic [31:0] d);
      bit done;
      done = 1'b0;
      set_req(dut, mem, 1'b1, a, d);
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge CLOCK);
         done = get_ready(dut, mem);
         @(posedge CLOCK);
         #1;
      end
      set_req(dut, mem, 1'b0, 5'd0, 32'd0);
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send dut%0d mem=%0b: got no accept in 50 cycles, required accept", dut, mem);
      end
   endtask

   task automatic drain(input int dut, input string name);
      for (int t = 0; t < 40; t++) begin
         if ((dut == 0 ? q0.size() : q1.size()) == 0) break;
         @(posedge CLOCK);
      end
      repeat (3) @(posedge CLOCK);
      #1;
      check(name, (dut == 0) ? q0.size() : q1.size(), 32'd0);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      repeat (2) @(posedge CLOCK);
      #1 RESET_N = 1'b1;
   endtask

   initial begin
      logic [5:0] ea;
      logic [5:0] em;
      RESET_N = 1'b0;
      set_req(0, A, 1'b0, 5'd0, 32'd0);
      set_req(0, M, 1'b0, 5'd0, 32'd0);
      set_req(1, A, 1'b0, 5'd0, 32'd0);
      set_req(1, M, 1'b0, 5'd0, 32'd0);

      // Reset state
      do_reset();
      check("rst rf_we", {31'd0, bus0.RF_WE}, 32'd0);
      check("rst rf_a3", {27'd0, bus0.RF_A3}, 32'd0);
      check("rst rf_wd", bus0.RF_WD, 32'd0);
      check("rst grant_mem", {31'd0, bus0.GRANT_MEM}, 32'd0);
      check("rst busy", bus0.BUSY_MASK, 32'd0);
      check("rst readys", {30'd0, bus0.ALU_READY, bus0.MEM_READY}, 32'd3);
      check("rst dut1 busy/we", {bus1.BUSY_MASK[30:0], bus1.RF_WE}, 32'd0);

      // Single write, latency and busy window
      push_exp(0, 5'd5, 32'hDEADBEEF, A);
      send(0, A, 5'd5, 32'hDEADBEEF);
      @(negedge CLOCK);
      check("single busy after accept", bus0.BUSY_MASK, 32'h20);
      check("single we before grant edge", {31'd0, bus0.RF_WE}, 32'd0);
      @(negedge CLOCK);
      check("single busy in output", bus0.BUSY_MASK, 32'h20);
      check("single we", {31'd0, bus0.RF_WE}, 32'd1);
      @(negedge CLOCK);
      check("single busy cleared", bus0.BUSY_MASK, 32'd0);
      check("single we dropped", {31'd0, bus0.RF_WE}, 32'd0);
      check("single a3 held", {27'd0, bus0.RF_A3}, 32'd5);
      check("single wd held", bus0.RF_WD, 32'hDEADBEEF);
      @(posedge CLOCK);
      #1;
      drain(0, "single drain");

      // Round-robin contention, ALU reg1 vs MEM reg2
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_exp(0, 5'd1, 32'hA0 + i, A);
         push_exp(0, 5'd2, 32'hB0 + i, M);
      end
      ea = 6'b101011;
      em = 6'b010101;
      fork
         for (int i = 0; i < 4; i++) send(0, A, 5'd1, 32'hA0 + i);
         for (int i = 0; i < 4; i++) send(0, M, 5'd2, 32'hB0 + i);
         for (int c = 0; c < 6; c++) begin
            @(negedge CLOCK);
            check($sformatf("rr alu_ready c%0d", c), {31'd0, bus0.ALU_READY}, {31'd0, ea[c]});
            check($sformatf("rr mem_ready c%0d", c), {31'd0, bus0.MEM_READY}, {31'd0, em[c]});
         end
      join
      drain(0, "rr drain");

      // Same-address ordering under MEM priority (dut1)
      do_reset();
      push_exp(1, 5'd3, 32'h33, M);
      push_exp(1, 5'd7, 32'h1, A);
      push_exp(1, 5'd7, 32'h2, M);
      fork
         send(1, A, 5'd7, 32'h1);
         begin
            send(1, M, 5'd3, 32'h33);
            send(1, M, 5'd7, 32'h2);
         end
      join
      drain(1, "same-addr drain");

      // Simultaneous load on reg9 while round-robin points at MEM
      do_reset();
      push_exp(0, 5'd1, 32'h11, A);
      push_exp(0, 5'd2, 32'h22, M);
      push_exp(0, 5'd9, 32'h91, A);
      push_exp(0, 5'd9, 32'h92, M);
      fork
         begin
            send(0, A, 5'd1, 32'h11);
            @(posedge CLOCK);
            #1;
            send(0, A, 5'd9, 32'h91);
         end
         begin
            send(0, M, 5'd2, 32'h22);
            send(0, M, 5'd9, 32'h92);
         end
      join
      drain(0, "tie drain");

      // Register 0 write is dropped but frees its slot
      do_reset();
      send(0, M, 5'd0, 32'h55);
      @(negedge CLOCK);
      check("r0 busy", bus0.BUSY_MASK, 32'd0);
      check("r0 mem_ready", {31'd0, bus0.MEM_READY}, 32'd1);
      @(negedge CLOCK);
      check("r0 we", {31'd0, bus0.RF_WE}, 32'd0);
      check("r0 busy after", bus0.BUSY_MASK, 32'd0);
      @(posedge CLOCK);
      #1;
      push_exp(0, 5'd4, 32'h44, M);
      send(0, M, 5'd4, 32'h44);
      drain(0, "r0 drain");

      // Fixed priority: MEM always wins, ALU starves until MEM stops
      do_reset();
      for (int i = 0; i < 4; i++) push_exp(1, 5'd11, 32'hC0 + i, M);
      push_exp(1, 5'd10, 32'hD0, A);
      push_exp(1, 5'd10, 32'hD1, A);
      fork
         begin
            send(1, A, 5'd10, 32'hD0);
            send(1, A, 5'd10, 32'hD1);
         end
         for (int i = 0; i < 4; i++) send(1, M, 5'd11, 32'hC0 + i);
         begin
            @(negedge CLOCK);
            for (int c = 1; c < 5; c++) begin
               @(negedge CLOCK);
               check($sformatf("prio alu_ready c%0d", c), {31'd0, bus1.ALU_READY}, 32'd0);
               check($sformatf("prio mem_ready c%0d", c), {31'd0, bus1.MEM_READY}, 32'd1);
            end
         end
      join
      drain(1, "prio drain");

      // Reset mid-stream with both slots full and a write on the port
      do_reset();
      push_exp(0, 5'd12, 32'hE0, A);
      fork
         begin
            send(0, A, 5'd12, 32'hE0);
            send(0, A, 5'd12, 32'hE1);
         end
         begin
            send(0, M, 5'd13, 32'hF0);
            send(0, M, 5'd13, 32'hF1);
         end
      join
      check("mid busy before reset", bus0.BUSY_MASK, 32'h3000);
      check("mid we before reset", {31'd0, bus0.RF_WE}, 32'd1);
      #1 RESET_N = 1'b0;
      #1;
      check("mid we in reset", {31'd0, bus0.RF_WE}, 32'd0);
      check("mid busy in reset", bus0.BUSY_MASK, 32'd0);
      @(posedge CLOCK);
      #1 RESET_N = 1'b1;
      @(negedge CLOCK);
      check("mid readys after", {30'd0, bus0.ALU_READY, bus0.MEM_READY}, 32'd3);
      check("mid busy after", bus0.BUSY_MASK, 32'd0);
      drain(0, "mid drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
